// File: rtl/riscv_mini_pipe.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mini_pipe
// Purpose  : Two-stage pipelined mini RISC-V style core with a 16-bit
//            instruction word. Stage 0 accepts an instruction, reads its
//            operands with forwarding from stage 1, and latches everything
//            into S1. Stage 1 executes and then either writes the register
//            file or loads the back-pressured result register (OUT class).
// Ports    : clk          - clock
//            rst_n        - synchronous active-low reset
//            instr        - 16-bit instruction word
//            instr_valid  - instr is valid this cycle
//            instr_ready  - core accepts instr this cycle
//            result       - registered OUT value
//            result_valid - result holds an unconsumed value
//            result_ready - consumer takes result this cycle
// Revision : 1.0 - initial release
// ============================================================================
module riscv_mini_pipe #(
  parameter int WIDTH     = 8,
  parameter int NUM_REGS  = 8,
  parameter int REG0_ZERO = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready
);

  localparam logic [1:0] OP_R   = 2'b00;
  localparam logic [1:0] OP_I   = 2'b01;
  localparam logic [1:0] OP_L   = 2'b10;
  localparam logic [1:0] OP_OUT = 2'b11;

  function automatic logic [WIDTH-1:0] alu(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [3:0]       ctrl);
    logic [2:0]       sh;
    logic [WIDTH-1:0] y;
    sh = b[2:0];
    y  = '0;
    case (ctrl)
      4'b0000: y = a + b;
      4'b1000: y = a - b;
      4'b0001: y = a << sh;
      4'b0101: y = a >> sh;
      4'b1101: y = $unsigned($signed(a) >>> sh);
      4'b0010: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b0011: y = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b0100: y = a ^ b;
      4'b0110: y = a | b;
      4'b0111: y = a & b;
      default: y = '0;
    endcase
    return y;
  endfunction

  // Which of the eight encodable indices hold real, writable storage.
  // Anything else reads as zero and swallows writes.
  logic [7:0] writable;
  for (genvar gi = 0; gi < 8; gi++) begin : g_wmask
    assign writable[gi] = (gi < NUM_REGS) && !((gi == 0) && (REG0_ZERO != 0));
  end

  logic [WIDTH-1:0] rf [8];

  // Stage 1 state
  logic             s1_valid;
  logic [1:0]       s1_op;
  logic [2:0]       s1_rd;
  logic [2:0]       s1_f3;
  logic [1:0]       s1_f2;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_imm;

  logic             s1_fire;
  logic             wb_en;
  logic [WIDTH-1:0] wb_val;
  logic [WIDTH-1:0] out_val;

  // An OUT can only retire when the result register has room (or is being
  // drained this very cycle); writeback classes never stall.
  assign s1_fire     = s1_valid && ((s1_op != OP_OUT) || !result_valid || result_ready);
  assign instr_ready = !s1_valid || s1_fire;
  assign wb_en       = s1_fire && (s1_op != OP_OUT) && writable[s1_rd];

  always_comb begin
    wb_val  = '0;
    out_val = '0;
    case (s1_op)
      OP_R: wb_val = alu(s1_a, s1_b, {s1_f2[0], s1_f3});
      OP_I: wb_val = alu(s1_a, s1_imm, {1'b0, s1_f3});
      OP_L: wb_val = s1_imm;
      default: begin
        if (s1_f3 == 3'b000) begin
          out_val = s1_a;
        end else if (s1_f3 == 3'b011) begin
          out_val = {{(WIDTH-1){1'b0}}, ((s1_a == s1_b) ^ s1_f2[1])};
        end else if ((s1_f3 == 3'b111) && !s1_f2[1]) begin
          out_val = alu(s1_a, s1_b, {s1_f2[0], 3'b111});
        end else begin
          out_val = '0;
        end
      end
    endcase
  end

  // Stage 0: decode and operand read with forwarding of the value S1 is
  // writing back at this same edge, so dependent pairs issue back-to-back.
  logic [2:0]       rs1_idx;
  logic [2:0]       rs2_idx;
  logic [WIDTH-1:0] rs1_val;
  logic [WIDTH-1:0] rs2_val;
  logic [WIDTH-1:0] imm_dec;
  logic             accept;

  assign rs1_idx = instr[7:5];
  assign rs2_idx = instr[10:8];
  assign accept  = instr_valid && instr_ready;

  always_comb begin
    rs1_val = writable[rs1_idx] ? rf[rs1_idx] : '0;
    rs2_val = writable[rs2_idx] ? rf[rs2_idx] : '0;
    if (wb_en && (s1_rd == rs1_idx)) rs1_val = wb_val;
    if (wb_en && (s1_rd == rs2_idx)) rs2_val = wb_val;
    if (instr[1:0] == OP_L) begin
      imm_dec = WIDTH'(instr[15:8]);
    end else begin
      imm_dec = WIDTH'($signed(instr[12:8]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (instr_ready) begin
      s1_valid <= instr_valid;
    end
  end

  // Payload needs no reset: it is only observed while s1_valid is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op  <= instr[1:0];
      s1_rd  <= instr[4:2];
      s1_f2  <= instr[12:11];
      s1_f3  <= instr[15:13];
      s1_a   <= rs1_val;
      s1_b   <= rs2_val;
      s1_imm <= imm_dec;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (!rst_n) begin
        rf[i] <= '0;
      end else if (wb_en && (s1_rd == 3'(i))) begin
        rf[i] <= wb_val;
      end
    end
  end

  // A retiring OUT overwrites the register even when the old value is being
  // consumed this cycle, keeping result_valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else if (s1_fire && (s1_op == OP_OUT)) begin
      result       <= out_val;
      result_valid <= 1'b1;
    end else if (result_ready) begin
      result_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_mini_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_mini_pipe
// Purpose  : Self-checking bench for riscv_mini_pipe. Accepted instructions
//            run through an architectural reference model; OUT results are
//            queued and compared by an independent monitor whenever the
//            core hands over a result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mini_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [7:0]  result;
  logic        result_valid;
  logic        result_ready = 1'b1;

  riscv_mini_pipe #(.WIDTH(8), .NUM_REGS(8), .REG0_ZERO(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int mregs[8];
  bit rand_rr = 1'b0;

  task automatic check(input string name, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, expv);
    end
  endtask

  // Reference ALU on plain integers, 8-bit wraparound.
  function automatic int alu_m(input int a, input int b, input int c);
    int sh = b % 8;
    int sa = (a > 127) ? a - 256 : a;
    int sb = (b > 127) ? b - 256 : b;
    case (c)
      0:  return (a + b) & 255;
      8:  return (a - b) & 255;
      1:  return (a << sh) & 255;
      5:  return a >> sh;
      13: return (sa >>> sh) & 255;
      2:  return (sa < sb) ? 1 : 0;
      3:  return (a < b) ? 1 : 0;
      4:  return a ^ b;
      6:  return a | b;
      7:  return a & b;
      default: return 0;
    endcase
  endfunction

  // Executes one instruction architecturally, in acceptance order.
  function automatic void model_exec(input logic [15:0] w);
    int op    = int'(w[1:0]);
    int rd    = int'(w[4:2]);
    int a     = mregs[w[7:5]];
    int b     = mregs[w[10:8]];
    int f3    = int'(w[15:13]);
    int f2    = int'(w[12:11]);
    int imm_i = w[12] ? int'(w[12:8]) - 32 : int'(w[12:8]);
    int imm_l = int'(w[15:8]);
    int v     = 0;
    imm_i = imm_i & 255;
    case (op)
      0: v = alu_m(a, b, (f2 % 2) * 8 + f3);
      1: v = alu_m(a, imm_i, f3);
      2: v = imm_l;
      default: begin
        if (f3 == 0)                  v = a;
        else if (f3 == 3)             v = ((a == b) ? 1 : 0) ^ (f2 / 2);
        else if (f3 == 7 && f2 < 2)   v = alu_m(a, b, (f2 % 2) * 8 + 7);
        else                          v = 0;
        exp_q.push_back(v);
      end
    endcase
    if (op != 3 && rd != 0) mregs[rd] = v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 0;
    exp_q.delete();
  endfunction

  // Caller must be just after a rising edge. Returns at rising edge + 1.
  task automatic send(input logic [15:0] w, output int waits);
    waits = 0;
    instr = w;
    instr_valid = 1'b1;
    @(negedge clk);
    while (!instr_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!instr_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: instr=0x%h got=not accepted expected=accepted", w);
    end else begin
      model_exec(w);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  // Scoreboard monitor: a result transfers whenever valid && ready at an edge.
  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL result_unexpected: got=0x%0h expected=no result", result);
      end else begin
        check("result", int'(result), exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rr) begin
      #1;
      result_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt;
    logic [31:0] rnd;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_result_valid", int'(result_valid), 0);
    check("reset_result", int'(result), 0);
    check("reset_instr_ready", int'(instr_ready), 1);
    @(posedge clk);
    #1;

    // Load then OUT back-to-back; check one-cycle result latency.
    send(16'h2506, wt);
    send(16'h0023, wt);
    @(negedge clk);
    check("latency_early", int'(result_valid), 0);
    @(negedge clk);
    check("latency_valid", int'(result_valid), 1);
    check("latency_value", int'(result), 8'h25);
    @(posedge clk);
    #1;

    // Dependent pair through forwarding, no stall.
    send(16'h0329, wt);
    send(16'h0043, wt);
    check("fwd_no_stall", wt, 0);
    send(16'h1F0D, wt);
    send(16'h0063, wt);
    send(16'h5502, wt);
    send(16'h0003, wt);

    // Equality compare forms.
    send(16'h0506, wt);
    send(16'h050A, wt);
    send(16'h6223, wt);
    send(16'h7223, wt);
    send(16'h060A, wt);
    send(16'h6223, wt);
    send(16'h7223, wt);
    repeat (3) @(posedge clk);
    #1;

    // Back-pressure: r1=5, r2=6, r3=0xFF.
    result_ready = 1'b0;
    send(16'h0023, wt);
    send(16'h0043, wt);
    check("stall_second_accept", wt, 0);
    instr = 16'h0063;
    instr_valid = 1'b1;
    @(negedge clk);
    check("stall_ready_low", int'(instr_ready), 0);
    check("stall_result_hold", int'(result), 5);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("stall_ready_low2", int'(instr_ready), 0);
    @(posedge clk);
    #1;
    result_ready = 1'b1;
    @(negedge clk);
    check("release_ready", int'(instr_ready), 1);
    model_exec(16'h0063);
    @(posedge clk);
    #1;
    result_ready = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    check("replace_value", int'(result), 6);
    check("replace_valid", int'(result_valid), 1);

    // Reset while the result is pending and S1 holds an OUT.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    check("midreset_result_valid", int'(result_valid), 0);
    check("midreset_result", int'(result), 0);
    check("midreset_instr_ready", int'(instr_ready), 1);
    @(posedge clk);
    #1;
    for (int r = 1; r < 8; r++) begin
      send({8'h00, 3'(r), 5'b00011}, wt);
    end

    // Randomized traffic with random consumer back-pressure.
    rand_rr = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        rnd = $urandom();
        send(rnd[15:0], wt);
      end
    end
    rand_rr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    result_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
